// File: rtl/acq_sequencer_pkg.sv
// Shared types and widths for the acquisition sequencer.
package acq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CORE_RST = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DELAY    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_READOUT  = 3'd5
  } acq_state_t;

  localparam int DLY_W      = 8;
  localparam int NUM_CH_DEF = 8;
  localparam int CH_W       = $clog2(NUM_CH_DEF);

endpackage

// File: rtl/acq_sequencer_if.sv
// Instruction, trigger and readout signals between the SPI side and the sequencer.
interface acq_sequencer_if
  import acq_seq_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int RD_CH_W = $clog2(NUM_CH)
);

  logic               inst_rst;
  logic               inst_start;
  logic               inst_readout;
  logic [NUM_CH-1:0]  trigger_channel_mask;
  logic [DLY_W-1:0]   trig_delay;
  logic [NUM_CH-1:0]  disc_in;
  logic               rd_ack;
  logic               core_rst;
  logic               acq_en;
  logic               trig_out;
  logic               rd_req;
  logic [RD_CH_W-1:0] rd_ch;
  logic               busy;
  logic [2:0]         state_dbg;

  modport master (
    output inst_rst, inst_start, inst_readout, trigger_channel_mask,
           trig_delay, disc_in, rd_ack,
    input  core_rst, acq_en, trig_out, rd_req, rd_ch, busy, state_dbg
  );

  modport slave (
    input  inst_rst, inst_start, inst_readout, trigger_channel_mask,
           trig_delay, disc_in, rd_ack,
    output core_rst, acq_en, trig_out, rd_req, rd_ch, busy, state_dbg
  );

endinterface

// File: rtl/acq_sequencer_sync_edge_det.sv
// Brings one asynchronous instruction level into iclk and emits a single-cycle
// event on each rising edge; the event itself is registered.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      ev     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      ev     <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Sequences the analog core through reset, arming, trigger delay, hold and
// channel readout, driven by the SPI instruction levels.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 16,
  parameter int NUM_CH      = NUM_CH_DEF
) (
  input logic            iclk,
  input logic            rst,
  acq_sequencer_if.slave bus
);

  localparam int RD_CH_W = $clog2(NUM_CH);
  localparam int RCNT_W  = $clog2(RST_CYCLES + 1);
  localparam logic [RD_CH_W-1:0] LAST_CH = RD_CH_W'(NUM_CH - 1);

  logic ev_rst, ev_start, ev_readout, hit;

  acq_state_t         state_q, state_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic               pend_q, pend_d;
  logic               core_rst_q, core_rst_d;
  logic               acq_en_q, acq_en_d;
  logic               trig_out_q, trig_out_d;
  logic               rd_req_q, rd_req_d;
  logic [RD_CH_W-1:0] rd_ch_q, rd_ch_d;
  logic               busy_q;
  logic [2:0]         state_dbg_q;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
    .clk(iclk), .rst(rst), .din(bus.inst_rst), .ev(ev_rst)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk(iclk), .rst(rst), .din(bus.inst_start), .ev(ev_start)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_readout (
    .clk(iclk), .rst(rst), .din(bus.inst_readout), .ev(ev_readout)
  );

  assign hit = |(bus.disc_in & bus.trigger_channel_mask);

  // Every output is computed as a next value here and registered below, so
  // busy/state_dbg always describe the state that becomes current on the edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_cnt_d  = rst_cnt_q;
    pend_d     = pend_q;
    core_rst_d = core_rst_q;
    acq_en_d   = acq_en_q;
    trig_out_d = 1'b0;
    rd_req_d   = rd_req_q;
    rd_ch_d    = rd_ch_q;

    if (ev_rst) begin
      state_d    = ST_CORE_RST;
      rst_cnt_d  = RCNT_W'(RST_CYCLES - 1);
      core_rst_d = 1'b1;
      acq_en_d   = 1'b0;
      pend_d     = 1'b0;
      rd_req_d   = 1'b0;
      rd_ch_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev_readout) begin
            state_d  = ST_READOUT;
            rd_req_d = 1'b1;
            rd_ch_d  = '0;
          end else if (ev_start) begin
            state_d  = ST_ARMED;
            acq_en_d = 1'b1;
          end
        end
        ST_CORE_RST: begin
          if (rst_cnt_q == '0) begin
            state_d    = ST_IDLE;
            core_rst_d = 1'b0;
          end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
          end
        end
        ST_ARMED: begin
          if (ev_readout) begin
            state_d  = ST_READOUT;
            acq_en_d = 1'b0;
            rd_req_d = 1'b1;
            rd_ch_d  = '0;
          end else if (hit) begin
            state_d = ST_DELAY;
            cnt_d   = bus.trig_delay;
          end
        end
        // A readout request arriving mid-delay is remembered until HOLD.
        ST_DELAY: begin
          if (ev_readout) pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d    = ST_HOLD;
            trig_out_d = 1'b1;
            acq_en_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (ev_readout || pend_q) begin
            state_d  = ST_READOUT;
            pend_d   = 1'b0;
            rd_req_d = 1'b1;
            rd_ch_d  = '0;
          end
        end
        ST_READOUT: begin
          if (rd_req_q && bus.rd_ack) begin
            if (rd_ch_q == LAST_CH) begin
              state_d  = ST_IDLE;
              rd_req_d = 1'b0;
              rd_ch_d  = '0;
            end else begin
              rd_ch_d = rd_ch_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      pend_q      <= 1'b0;
      core_rst_q  <= 1'b0;
      acq_en_q    <= 1'b0;
      trig_out_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_ch_q     <= '0;
      busy_q      <= 1'b0;
      state_dbg_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      pend_q      <= pend_d;
      core_rst_q  <= core_rst_d;
      acq_en_q    <= acq_en_d;
      trig_out_q  <= trig_out_d;
      rd_req_q    <= rd_req_d;
      rd_ch_q     <= rd_ch_d;
      busy_q      <= (state_d != ST_IDLE);
      state_dbg_q <= state_d;
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.acq_en    = acq_en_q;
  assign bus.trig_out  = trig_out_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_ch     = rd_ch_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_dbg_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: reset pulse, trigger delay, masking,
// readout handshake, abort and event priority.
module tb_acq_sequencer;
  import acq_seq_pkg::*;

  logic iclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 iclk = ~iclk;

  acq_sequencer_if #(.NUM_CH(8)) bus ();

  acq_sequencer #(.SYNC_STAGES(2), .RST_CYCLES(16), .NUM_CH(8)) dut (
    .iclk(iclk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic ro);
    bus.inst_rst     = r;
    bus.inst_start   = s;
    bus.inst_readout = ro;
  endtask

  // Called with core_rst just seen high; counts its high cycles until it drops.
  task automatic measureCoreRst(input string tag);
    int n;
    n = 1;
    for (int i = 0; i < 40 && bus.core_rst === 1'b1; i++) begin
      tick();
      if (bus.core_rst === 1'b1) n++;
    end
    checkOutput({tag, "_len"}, n, 16);
    checkOutput({tag, "_idle"}, bus.state_dbg, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int stall;
    applyStimulus(0, 0, 0);
    bus.trigger_channel_mask = 8'h00;
    bus.trig_delay           = 8'd0;
    bus.disc_in              = 8'h00;
    bus.rd_ack               = 1'b0;
    rst = 1'b1;
    tick(2);
    checkOutput("rst_state", bus.state_dbg, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_core_rst", bus.core_rst, 0);
    checkOutput("rst_acq_en", bus.acq_en, 0);
    checkOutput("rst_rd_req", bus.rd_req, 0);
    checkOutput("rst_rd_ch", bus.rd_ch, 0);
    checkOutput("rst_trig_out", bus.trig_out, 0);
    rst = 1'b0;
    tick();

    // 1: reset instruction
    applyStimulus(1, 0, 0);
    tick(3);
    checkOutput("t1_sync_latency", bus.core_rst, 0);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("t1_core_rst_on", bus.core_rst, 1);
    checkOutput("t1_state", bus.state_dbg, 1);
    checkOutput("t1_busy", bus.busy, 1);
    measureCoreRst("t1_core_rst");

    // 2: arm, trigger with delay 5
    bus.trigger_channel_mask = 8'h04;
    bus.trig_delay           = 8'd5;
    applyStimulus(0, 1, 0);
    tick(3);
    checkOutput("t2_not_yet_armed", bus.state_dbg, 0);
    tick();
    checkOutput("t2_armed", bus.state_dbg, 2);
    checkOutput("t2_acq_en", bus.acq_en, 1);
    applyStimulus(0, 0, 0);
    bus.disc_in = 8'h04;
    tick();
    checkOutput("t2_delay", bus.state_dbg, 3);
    bus.disc_in    = 8'h00;
    bus.trig_delay = 8'd40;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("t2_trig_wait", bus.trig_out, 0);
    end
    checkOutput("t2_acq_en_hold", bus.acq_en, 1);
    tick();
    checkOutput("t2_trig_out", bus.trig_out, 1);
    checkOutput("t2_acq_en_off", bus.acq_en, 0);
    checkOutput("t2_hold", bus.state_dbg, 4);
    tick();
    checkOutput("t2_trig_one_cycle", bus.trig_out, 0);
    checkOutput("t2_hold_stays", bus.state_dbg, 4);

    // 4: readout from HOLD with stalled acks
    applyStimulus(0, 0, 1);
    tick(3);
    checkOutput("t4_still_hold", bus.state_dbg, 4);
    tick();
    checkOutput("t4_readout", bus.state_dbg, 5);
    checkOutput("t4_rd_req", bus.rd_req, 1);
    checkOutput("t4_rd_ch0", bus.rd_ch, 0);
    applyStimulus(0, 0, 0);
    for (int ch = 0; ch < 8; ch++) begin
      stall = $urandom_range(0, 2);
      bus.rd_ack = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        checkOutput("t4_rd_ch_stall", bus.rd_ch, ch);
      end
      checkOutput("t4_rd_req_held", bus.rd_req, 1);
      bus.rd_ack = 1'b1;
      tick();
      if (ch < 7) begin
        checkOutput("t4_rd_ch_adv", bus.rd_ch, ch + 1);
      end else begin
        checkOutput("t4_rd_req_done", bus.rd_req, 0);
        checkOutput("t4_rd_ch_done", bus.rd_ch, 0);
        checkOutput("t4_idle", bus.state_dbg, 0);
      end
    end
    tick();
    checkOutput("t4_stray_ack_state", bus.state_dbg, 0);
    checkOutput("t4_stray_ack_rd_req", bus.rd_req, 0);
    bus.rd_ack = 1'b0;

    // 3: masked-out channel, zero mask, then zero delay
    applyStimulus(0, 1, 0);
    tick(4);
    checkOutput("t3_armed", bus.state_dbg, 2);
    applyStimulus(0, 0, 0);
    bus.disc_in = 8'h01;
    tick();
    bus.disc_in = 8'h00;
    tick(2);
    checkOutput("t3_masked_state", bus.state_dbg, 2);
    checkOutput("t3_masked_trig", bus.trig_out, 0);
    bus.trigger_channel_mask = 8'h00;
    bus.disc_in              = 8'hFF;
    tick();
    checkOutput("t3_zero_mask", bus.state_dbg, 2);
    bus.disc_in              = 8'h00;
    bus.trigger_channel_mask = 8'h04;
    bus.trig_delay           = 8'd0;
    bus.disc_in              = 8'h04;
    tick();
    checkOutput("t3_delay", bus.state_dbg, 3);
    bus.disc_in = 8'h00;
    tick();
    checkOutput("t3_trig_next_edge", bus.trig_out, 1);
    checkOutput("t3_hold", bus.state_dbg, 4);

    // back to IDLE via reset instruction from HOLD
    applyStimulus(1, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("t6_pre_core_rst", bus.state_dbg, 1);
    measureCoreRst("t6_pre_core_rst");

    // 6a: reset and readout together in ARMED
    applyStimulus(0, 1, 0);
    tick(4);
    checkOutput("t6_armed", bus.state_dbg, 2);
    applyStimulus(1, 0, 1);
    tick(3);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("t6_prio_state", bus.state_dbg, 1);
    checkOutput("t6_prio_rd_req", bus.rd_req, 0);
    checkOutput("t6_prio_acq_en", bus.acq_en, 0);
    measureCoreRst("t6_prio_core_rst");
    tick();
    checkOutput("t6_no_late_readout", bus.state_dbg, 0);

    // 6b: readout during DELAY is deferred until after HOLD
    applyStimulus(0, 1, 0);
    tick(4);
    checkOutput("t6b_armed", bus.state_dbg, 2);
    applyStimulus(0, 0, 0);
    bus.trig_delay = 8'd4;
    bus.disc_in    = 8'h04;
    tick();
    bus.disc_in = 8'h00;
    applyStimulus(0, 0, 1);
    tick(4);
    checkOutput("t6b_in_delay", bus.state_dbg, 3);
    tick();
    checkOutput("t6b_hold", bus.state_dbg, 4);
    checkOutput("t6b_trig", bus.trig_out, 1);
    tick();
    checkOutput("t6b_readout", bus.state_dbg, 5);
    checkOutput("t6b_rd_req", bus.rd_req, 1);
    checkOutput("t6b_rd_ch", bus.rd_ch, 0);
    applyStimulus(0, 0, 0);

    // 5: reset instruction aborts readout at channel 3
    bus.rd_ack = 1'b1;
    tick(3);
    bus.rd_ack = 1'b0;
    checkOutput("t5_rd_ch3", bus.rd_ch, 3);
    applyStimulus(1, 0, 0);
    tick(3);
    checkOutput("t5_pre_abort_state", bus.state_dbg, 5);
    checkOutput("t5_pre_abort_rd_ch", bus.rd_ch, 3);
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("t5_abort_state", bus.state_dbg, 1);
    checkOutput("t5_abort_rd_req", bus.rd_req, 0);
    checkOutput("t5_abort_rd_ch", bus.rd_ch, 0);
    checkOutput("t5_abort_core_rst", bus.core_rst, 1);
    measureCoreRst("t5_core_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
